// File: rtl/write_back_buf_if.sv
// write_back_buf_if: memory-stage input, register-file write port and forwarding lookup of the write-back stage.
interface write_back_buf_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [DATA_W-1:0] ans_dm;
  logic [DATA_W-1:0] ans_alu;
  logic [ADDR_W-1:0] in_rd;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] ans_wb;
  logic              rf_ready;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;
  logic [CNT_W-1:0]  retired;
  modport master (
    output in_valid, flush, ans_dm, ans_alu, in_rd, in_mem_to_reg, in_reg_write, rf_ready, q_addr,
    input  in_ready, rf_we, rf_addr, ans_wb, q_hit, q_data, retired
  );
  modport slave (
    input  in_valid, flush, ans_dm, ans_alu, in_rd, in_mem_to_reg, in_reg_write, rf_ready, q_addr,
    output in_ready, rf_we, rf_addr, ans_wb, q_hit, q_data, retired
  );
endinterface

// File: rtl/write_back_buf.sv
// write_back_buf: in-order write buffer feeding the register file, with forwarding lookup and retire counter.
module write_back_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic reset,
  write_back_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] rd_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, idx;
  logic [PW:0] count;
  logic accept, push, pop, nowrite, hit;
  logic [DATA_W-1:0] fwd;
  assign bus.in_ready = count < (PW+1)'(DEPTH);
  assign bus.rf_we = count != '0;
  assign bus.rf_addr = bus.rf_we ? rd_mem[rd_ptr] : '0;
  assign bus.ans_wb = bus.rf_we ? data_mem[rd_ptr] : '0;
  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;
  assign push = accept & bus.in_reg_write & (bus.in_rd != '0);
  assign nowrite = accept & ~push;
  assign pop = bus.rf_we & bus.rf_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.retired <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      bus.retired <= bus.retired + CNT_W'(nowrite) + CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      rd_mem[wr_ptr] <= bus.in_rd;
      data_mem[wr_ptr] <= bus.in_mem_to_reg ? bus.ans_dm : bus.ans_alu;
    end
  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((PW+1)'(i) < count && bus.q_addr != '0 && rd_mem[idx] == bus.q_addr) begin
        hit = 1'b1;
        fwd = data_mem[idx];
      end
    end
  end
  assign bus.q_hit = hit;
  assign bus.q_data = fwd;
endmodule
